// File: rtl/jump_pkg.sv
// Shared types and constants for the jump controller: FSM states, widths and LFSR taps.
package jump_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    FIRE = 2'd2,
    COOL = 2'd3
  } state_t;

  localparam int DELTA_W = 4;
  localparam int LFSR_W  = 8;

  // Feedback taps at bits 7,5,4,3: maximal-length sequence, never reaches zero.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stability counter and rising-edge detector for the player button.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic sys_clk,
  input  logic clr,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_reg;
  logic             btn_db_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             press_reg;
  logic             btn_s;

  assign btn_s = sync_reg[1];
  assign press = press_reg;

  // A new level is taken once btn_s has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      sync_reg   <= '0;
      btn_db_reg <= 1'b0;
      cnt_reg    <= '0;
      press_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn_raw};
      press_reg <= 1'b0;
      if (btn_s == btn_db_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        btn_db_reg <= btn_s;
        cnt_reg    <= '0;
        press_reg  <= btn_s;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/jump_controller.sv
// Turns debounced button presses into single enable_jump strobes carrying a random delta
// in 1..MAX_DELTA, followed by a cooldown during which further presses are dropped.
module jump_controller
  import jump_pkg::*;
#(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter int          COOLDOWN_CYCLES = 8,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5,
  parameter int          MAX_DELTA       = 6
) (
  input  logic               sys_clk,
  input  logic               clr,
  input  logic               btn_raw,
  output logic [DELTA_W-1:0] delta,
  output logic               enable_jump,
  output logic               busy,
  output logic [7:0]         roll_count
);

  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);

  logic               press;
  state_t             state_reg;
  logic [LFSR_W-1:0]  lfsr_reg;
  logic [DELTA_W-1:0] delta_reg;
  logic               enable_reg;
  logic               busy_reg;
  logic [7:0]         roll_count_reg;
  logic [COOL_W-1:0]  cool_reg;
  logic [2:0]         candidate;
  logic               candidate_ok;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .sys_clk(sys_clk),
    .clr    (clr),
    .btn_raw(btn_raw),
    .press  (press)
  );

  assign candidate    = lfsr_reg[2:0];
  assign candidate_ok = (candidate != 3'd0) && (int'(candidate) <= MAX_DELTA);

  assign delta       = delta_reg;
  assign enable_jump = enable_reg;
  assign busy        = busy_reg;
  assign roll_count  = roll_count_reg;

  always_ff @(posedge sys_clk) begin
    if (clr) begin
      state_reg      <= IDLE;
      lfsr_reg       <= SEED_EFF;
      delta_reg      <= '0;
      enable_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      roll_count_reg <= '0;
      cool_reg       <= '0;
    end else begin
      lfsr_reg   <= lfsr_next(lfsr_reg);
      enable_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (press) begin
            state_reg <= ROLL;
            busy_reg  <= 1'b1;
          end
        end
        // Out-of-range candidates simply wait for the next LFSR value.
        ROLL: begin
          if (candidate_ok) begin
            delta_reg  <= {1'b0, candidate};
            enable_reg <= 1'b1;
            state_reg  <= FIRE;
          end
        end
        FIRE: begin
          roll_count_reg <= roll_count_reg + 8'd1;
          cool_reg       <= '0;
          state_reg      <= COOL;
        end
        COOL: begin
          if (cool_reg == COOL_W'(COOLDOWN_CYCLES - 1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cool_reg <= cool_reg + COOL_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

endmodule
